regfile_write_arbiter: RTL

- Shares the register file's single write port (write address, write data, write strobe) among NUM_REQ writeback requesters, e.g. ALU result and memory-load result.
- Round-robin grant with a valid/ready handshake per requester.
- Registered output stage drives the register-file write port.
- Sits between the writeback sources and the register-file wrapper; the wrapper's RegWrite input is fed from wr_en.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Consumers import regfile_pkg::* for address/data types and the output-stage state enum.
package regfile_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Register 0 is hard-wired; writes to it are accepted but never committed.
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr.
// The pointer register is owned by the parent so it can advance only on a real transfer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] w_idx;

  // NOTE: every output gets a default before the search loop so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_idx       = '0;
    if (enable) begin
      // Walk from farthest to nearest so the last hit is the highest-priority one.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        w_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
        if (req[w_idx]) begin
          grant        = '0;
          grant[w_idx] = 1'b1;
          grant_idx    = w_idx;
          grant_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ writeback sources.
// Optional macro REGFILE_WR_BYPASS_EN forwards the in-flight write onto the read data outputs.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic                        stall,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [CNT_W-1:0]            wr_count,
  input  logic [ADDR_W-1:0]           rd_addr1,
  input  logic [ADDR_W-1:0]           rd_addr2,
  input  logic [DATA_W-1:0]           rf_data1,
  input  logic [DATA_W-1:0]           rf_data2,
  output logic [DATA_W-1:0]           fwd_data1,
  output logic [DATA_W-1:0]           fwd_data2
);

  localparam int IDX_W = $clog2(NUM_REQ);

  wr_state_t          r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic [IDX_W-1:0]   r_grant_id;
  logic [CNT_W-1:0]   r_wr_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_nonzero;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (r_rr_ptr),
    .enable      (~stall),
    .grant       (w_grant),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  assign req_ready     = w_grant;
  assign w_sel_addr    = req_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_sel_data    = req_data[w_grant_idx*DATA_W +: DATA_W];
  assign w_sel_nonzero = (w_sel_addr != ADDR_W'(REG_ZERO));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
      r_wr_count <= '0;
    end else begin
      r_state <= IDLE;
      if (w_grant_valid) begin
        r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        // A zero-address transfer is consumed but leaves the write port untouched.
        if (w_sel_nonzero) begin
          r_state    <= WRITE;
          r_wr_addr  <= w_sel_addr;
          r_wr_data  <= w_sel_data;
          r_grant_id <= w_grant_idx;
          r_wr_count <= r_wr_count + 1'b1;
        end
      end
    end
  end

  assign wr_en    = (r_state == WRITE);
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign grant_id = r_grant_id;
  assign wr_count = r_wr_count;

`ifdef REGFILE_WR_BYPASS_EN
  // Same-cycle read-after-write: the write on the port wins over stale array data.
  assign fwd_data1 = (wr_en && (r_wr_addr == rd_addr1) && (rd_addr1 != ADDR_W'(REG_ZERO)))
                     ? r_wr_data : rf_data1;
  assign fwd_data2 = (wr_en && (r_wr_addr == rd_addr2) && (rd_addr2 != ADDR_W'(REG_ZERO)))
                     ? r_wr_data : rf_data2;
`else
  assign fwd_data1 = rf_data1;
  assign fwd_data2 = rf_data2;
`endif

endmodule
